// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os
// Purpose  : Oversampling UART receiver (5-9 data bits, optional parity,
//            1-2 stop bits) with a valid/ready frame output and error flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int             CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]  CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [3:0]     IDX_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]     IDX_ONE   = 4'd1;
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic           PAR_EXP   = 1'(PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state, state_next;
  logic                   sync_q, rx_s, prev_s;
  logic [CW-1:0]          cnt, cnt_next;
  logic [3:0]             bit_idx, idx_next;
  logic                   stop_idx, stop_next;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_err_acc, frm_err_acc;
  logic                   shift_en, par_smp, stop_smp, frame_done;
  logic                   frm_final;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = bit_idx;
    stop_next  = stop_idx;
    shift_en   = 1'b0;
    par_smp    = 1'b0;
    stop_smp   = 1'b0;
    frame_done = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (!rx_s && prev_s) begin
            state_next = S_START;
            cnt_next   = '0;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt_next = '0;
            idx_next = '0;
            state_next = rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            shift_en = 1'b1;
            cnt_next = '0;
            idx_next = bit_idx + IDX_ONE;
            if (bit_idx == IDX_LAST) begin
              state_next = (PARITY != 0) ? S_PARITY : S_STOP;
              stop_next  = 1'b0;
            end
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            par_smp    = 1'b1;
            cnt_next   = '0;
            stop_next  = 1'b0;
            state_next = S_STOP;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            stop_smp = 1'b1;
            cnt_next = '0;
            // Leave at mid-bit of the last stop bit to gain resync margin.
            if (stop_idx == STOP_LAST) begin
              state_next = S_IDLE;
              frame_done = 1'b1;
            end else begin
              stop_next = 1'b1;
            end
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign frm_final = frm_err_acc | ~rx_s;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 1'b1;
      rx_s        <= 1'b1;
      prev_s      <= 1'b1;
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      shreg       <= '0;
      par_err_acc <= 1'b0;
      frm_err_acc <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      sync_q      <= rx;
      rx_s        <= sync_q;
      state       <= state_next;
      cnt         <= cnt_next;
      bit_idx     <= idx_next;
      stop_idx    <= stop_next;
      overrun_err <= 1'b0;
      if (tick) begin
        prev_s <= rx_s;
      end
      if (state == S_START && state_next == S_DATA) begin
        par_err_acc <= 1'b0;
        frm_err_acc <= 1'b0;
      end
      if (shift_en) begin
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      end
      if (par_smp) begin
        par_err_acc <= ((^shreg) ^ rx_s) != PAR_EXP;
      end
      if (stop_smp && !rx_s) begin
        frm_err_acc <= 1'b1;
      end
      // A completed frame loads only if the output slot is free this cycle.
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= par_err_acc;
          frame_err  <= frm_final;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_os
// Purpose  : Self-checking bench for uart_rx_os over five frame formats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

  localparam int NI  = 5;
  localparam int BIT = 64;

  function automatic int db_of(input int i);
    case (i)
      3: return 5;
      4: return 9;
      default: return 8;
    endcase
  endfunction
  function automatic int par_of(input int i);
    case (i)
      1: return 2;
      4: return 1;
      default: return 0;
    endcase
  endfunction
  function automatic int sb_of(input int i);
    case (i)
      2, 4: return 2;
      default: return 1;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx_v [NI];
  logic       rdy_v[NI];
  logic [8:0] dat  [NI];
  logic       val  [NI];
  logic       pe   [NI];
  logic       fe   [NI];
  logic       ov   [NI];
  logic       bsy  [NI];

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int P_DB = db_of(g);
      logic [P_DB-1:0] dw;
      uart_rx_os #(
        .DATA_BITS (P_DB),
        .PARITY    (par_of(g)),
        .STOP_BITS (sb_of(g)),
        .OVERSAMPLE(16)
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_v[g]),
        .tick       (tick),
        .rx_data    (dw),
        .rx_valid   (val[g]),
        .rx_ready   (rdy_v[g]),
        .parity_err (pe[g]),
        .frame_err  (fe[g]),
        .overrun_err(ov[g]),
        .busy       (bsy[g])
      );
      assign dat[g] = 9'(dw);
    end
  endgenerate

  initial forever #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  typedef struct {
    int         inst;
    logic [8:0] d;
    logic       p;
    logic       f;
  } rec_t;

  rec_t got[$];
  int   ocnt[NI];
  int   vcnt[NI];
  int   rd = 0;
  int   checks = 0;
  int   errors = 0;

  // Accepted transfers, valid cycles and overrun pulses, sampled after inputs settle.
  always begin
    @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (val[i]) vcnt[i] = vcnt[i] + 1;
      if (ov[i])  ocnt[i] = ocnt[i] + 1;
      if (val[i] && rdy_v[i]) got.push_back('{i, dat[i], pe[i], fe[i]});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Serialises one frame of instance i; nlim truncates it to model a cut-off frame.
  task automatic send(input int i, input logic [8:0] d, input bit badp,
                      input logic [1:0] bads, input int nlim);
    logic [12:0] fr;
    logic        p;
    int          n;
    fr = '1;
    fr[0] = 1'b0;
    n = 1;
    p = 1'b0;
    for (int k = 0; k < db_of(i); k++) begin
      fr[n] = d[k];
      p = p ^ d[k];
      n++;
    end
    if (par_of(i) != 0) begin
      fr[n] = ((par_of(i) == 1) ? ~p : p) ^ badp;
      n++;
    end
    for (int k = 0; k < sb_of(i); k++) begin
      fr[n] = ~bads[k];
      n++;
    end
    if (nlim < n) n = nlim;
    for (int k = 0; k < n; k++) begin
      rx_v[i] = fr[k];
      repeat (BIT) @(negedge clk);
    end
    rx_v[i] = 1'b1;
  endtask

  task automatic expect_one(input string name, input int i, input logic [8:0] ed,
                            input logic ep, input logic ef);
    repeat (BIT) @(negedge clk);
    #2;
    chk({name, "_count"}, got.size() - rd, 1);
    if (got.size() > rd) begin
      chk({name, "_inst"}, got[rd].inst, i);
      chk({name, "_data"}, got[rd].d, ed);
      chk({name, "_perr"}, got[rd].p, ep);
      chk({name, "_ferr"}, got[rd].f, ef);
      rd = got.size();
    end
  endtask

  typedef struct {
    int         inst;
    logic [8:0] d;
    bit         bp;
    logic [1:0] bs;
    logic [8:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t vt[9];

  initial begin
    int         i0, v0, o0;
    logic [8:0] d;
    logic [8:0] ed;
    bit         bp;
    logic [1:0] bs;
    logic       ep, ef;

    vt[0] = '{0, 9'h0A5, 1'b0, 2'b00, 9'h0A5, 1'b0, 1'b0};
    vt[1] = '{1, 9'h037, 1'b0, 2'b00, 9'h037, 1'b0, 1'b0};
    vt[2] = '{1, 9'h037, 1'b1, 2'b00, 9'h037, 1'b1, 1'b0};
    vt[3] = '{2, 9'h0C9, 1'b0, 2'b10, 9'h0C9, 1'b0, 1'b1};
    vt[4] = '{2, 9'h0C9, 1'b0, 2'b01, 9'h0C9, 1'b0, 1'b1};
    vt[5] = '{3, 9'h015, 1'b0, 2'b00, 9'h015, 1'b0, 1'b0};
    vt[6] = '{4, 9'h1A5, 1'b1, 2'b00, 9'h1A5, 1'b1, 1'b0};
    vt[7] = '{4, 9'h100, 1'b0, 2'b00, 9'h100, 1'b0, 1'b0};
    vt[8] = '{0, 9'h000, 1'b0, 2'b01, 9'h000, 1'b0, 1'b1};

    for (int i = 0; i < NI; i++) begin
      rx_v[i]  = 1'b1;
      rdy_v[i] = 1'b1;
      ocnt[i]  = 0;
      vcnt[i]  = 0;
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset_outs%0d", i), {dat[i], val[i], pe[i], fe[i], ov[i], bsy[i]}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (BIT) @(negedge clk);

    // Directed frames from the table.
    for (int t = 0; t < 9; t++) begin
      v0 = vcnt[vt[t].inst];
      send(vt[t].inst, vt[t].d, vt[t].bp, vt[t].bs, 99);
      expect_one($sformatf("vec%0d", t), vt[t].inst, vt[t].ed, vt[t].ep, vt[t].ef);
      chk($sformatf("vec%0d_valid_cycles", t), vcnt[vt[t].inst] - v0, 1);
    end

    // Break on 8N2: one all-zero frame with frame error, then no restart.
    rx_v[2] = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    #2;
    chk("break_busy_mid", bsy[2], 0);
    repeat (20 * BIT) @(negedge clk);
    #2;
    chk("break_count", got.size() - rd, 1);
    if (got.size() > rd) begin
      chk("break_data", got[rd].d, 0);
      chk("break_ferr", got[rd].f, 1);
      rd = got.size();
    end
    rx_v[2] = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    #2;
    chk("break_no_restart", got.size() - rd, 0);
    chk("break_busy_end", bsy[2], 0);
    send(2, 9'h05C, 1'b0, 2'b00, 99);
    expect_one("after_break", 2, 9'h05C, 1'b0, 1'b0);

    // Start-bit glitch of 5 ticks is dropped.
    rx_v[0] = 1'b0;
    repeat (12) @(negedge clk);
    #2;
    chk("glitch_busy_start", bsy[0], 1);
    repeat (8) @(negedge clk);
    rx_v[0] = 1'b1;
    repeat (36) @(negedge clk);
    #2;
    chk("glitch_busy_idle", bsy[0], 0);
    repeat (2 * BIT) @(negedge clk);
    #2;
    chk("glitch_no_frame", got.size() - rd, 0);

    // Overrun: second frame dropped while the first is held.
    o0 = ocnt[0];
    @(negedge clk);
    rdy_v[0] = 1'b0;
    send(0, 9'h011, 1'b0, 2'b00, 99);
    repeat (BIT) @(negedge clk);
    send(0, 9'h022, 1'b0, 2'b00, 99);
    repeat (BIT) @(negedge clk);
    #2;
    chk("ovr_valid_held", val[0], 1);
    chk("ovr_data_held", dat[0], 9'h011);
    chk("ovr_pulses", ocnt[0] - o0, 1);
    chk("ovr_none_accepted", got.size() - rd, 0);
    @(negedge clk);
    rdy_v[0] = 1'b1;
    @(negedge clk);
    #2;
    chk("ovr_valid_drop", val[0], 0);
    chk("ovr_accept_count", got.size() - rd, 1);
    if (got.size() > rd) begin
      chk("ovr_accept_data", got[rd].d, 9'h011);
      rd = got.size();
    end

    // Reset in the middle of a data phase discards the partial frame.
    for (int k = 0; k < 3; k++) begin
      i0 = (k == 0) ? 0 : (k == 1) ? 3 : 4;
      d  = (k == 0) ? 9'h05A : (k == 1) ? 9'h01A : 9'h15A;
      ed = (k == 0) ? 9'h0C3 : (k == 1) ? 9'h003 : 9'h1C3;
      send(i0, d, 1'b0, 2'b00, 4);
      #2;
      chk($sformatf("rst%0d_busy_before", i0), bsy[i0], 1);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      chk($sformatf("rst%0d_outs", i0),
          {dat[i0], val[i0], pe[i0], fe[i0], ov[i0], bsy[i0]}, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (BIT) @(negedge clk);
      send(i0, ed, 1'b0, 2'b00, 99);
      expect_one($sformatf("rst%0d_clean", i0), i0, ed, 1'b0, 1'b0);
    end

    // Random frames against the frame-level reference model.
    for (int n = 0; n < 30; n++) begin
      i0 = $urandom_range(0, NI - 1);
      d  = 9'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ed = d & 9'((1 << db_of(i0)) - 1);
      ep = (par_of(i0) != 0) && bp;
      ef = (sb_of(i0) == 2) ? (|bs) : bs[0];
      send(i0, d, bp, bs, 99);
      expect_one($sformatf("rand%0d", n), i0, ed, ep, ef);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
